// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared types and constants for the dual-master instruction fetch slice.
package rv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    M1   = 2'b01,
    M2   = 2'b10
  } mid_t;

  localparam logic [31:0] DEF_RESET_PC1 = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC2 = 32'hFFFF_FFFF;

  function automatic mid_t other_master(input mid_t m);
    return (m == M1) ? M2 : M1;
  endfunction

endpackage

// File: rtl/rv_fetch_master.sv
// rtl/rv_fetch_master.sv - one fetch master: free-running PC, pending data-phase PC, data capture.
module rv_fetch_master
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        a_grant,
  input  logic        d_grant,
  input  logic        rdy,
  input  logic [31:0] rdata,
  output logic [31:0] addr,
  output htrans_t     trans,
  output logic        instr_vld,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        vld_q, vld_d;
  logic        accept;
  logic        complete;

  // The request is presented whether or not this master owns the bus.
  always_comb begin
    trans    = req ? NONSEQ : IDLE;
    addr     = fetch_pc_q;
    accept   = a_grant && rdy && (trans == NONSEQ);
    complete = d_grant && rdy;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    vld_d      = complete;
    if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      pend_pc_d  = fetch_pc_q;
    end
    // Completion reads the old pending PC even when a new address is accepted on the same edge.
    if (complete) begin
      instr_d = rdata;
      pc_d    = pend_pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      instr_q    <= '0;
      pc_q       <= '0;
      vld_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      vld_q      <= vld_d;
    end
  end

  assign instr_vld = vld_q;
  assign instr     = instr_q;
  assign pc        = pc_q;

endmodule

// File: rtl/rv_dual_fetch_ahb.sv
// rtl/rv_dual_fetch_ahb.sv - two fetch masters sharing one pipelined read-only bus via a
// round-robin arbiter with separate address-phase and data-phase owners.
module rv_dual_fetch_ahb
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC1 = DEF_RESET_PC1,
  parameter logic [31:0] RESET_PC2 = DEF_RESET_PC2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req1,
  input  logic        req2,
  output logic [31:0] ABus,
  output logic [1:0]  TRANSBus,
  output logic [31:0] WDBus,
  input  logic [31:0] RDBus,
  input  logic        RDYBus,
  output logic        instr1_vld,
  output logic [31:0] instr1,
  output logic [31:0] pc1,
  output logic        instr2_vld,
  output logic [31:0] instr2,
  output logic [31:0] pc2
);

  mid_t        addr_owner_q, addr_owner_d;
  mid_t        data_owner_q, data_owner_d;
  logic        a_grant1, a_grant2;
  logic        d_grant1, d_grant2;
  logic [31:0] addr1, addr2;
  htrans_t     trans1, trans2, trans_bus;

  always_comb begin
    a_grant1 = (addr_owner_q == M1);
    a_grant2 = (addr_owner_q == M2);
    d_grant1 = (data_owner_q == M1);
    d_grant2 = (data_owner_q == M2);
  end

  rv_fetch_master #(.RESET_PC(RESET_PC1)) u_master1 (
    .clk       (clk),
    .rst       (rst_n),
    .req       (req1),
    .a_grant   (a_grant1),
    .d_grant   (d_grant1),
    .rdy       (RDYBus),
    .rdata     (RDBus),
    .addr      (addr1),
    .trans     (trans1),
    .instr_vld (instr1_vld),
    .instr     (instr1),
    .pc        (pc1)
  );

  rv_fetch_master #(.RESET_PC(RESET_PC2)) u_master2 (
    .clk       (clk),
    .rst       (rst_n),
    .req       (req2),
    .a_grant   (a_grant2),
    .d_grant   (d_grant2),
    .rdy       (RDYBus),
    .rdata     (RDBus),
    .addr      (addr2),
    .trans     (trans2),
    .instr_vld (instr2_vld),
    .instr     (instr2),
    .pc        (pc2)
  );

  // The address owner is never NONE, so master 1 is the fall-through side of the mux.
  always_comb begin
    ABus      = a_grant2 ? addr2 : addr1;
    trans_bus = a_grant2 ? trans2 : trans1;
  end

  assign TRANSBus = trans_bus;
  assign WDBus    = '0;

  always_comb begin
    addr_owner_d = addr_owner_q;
    data_owner_d = data_owner_q;
    if (RDYBus) begin
      data_owner_d = (trans_bus == NONSEQ) ? addr_owner_q : NONE;
      if (req1 && req2) begin
        addr_owner_d = other_master(addr_owner_q);
      end else if (req1) begin
        addr_owner_d = M1;
      end else if (req2) begin
        addr_owner_d = M2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      addr_owner_q <= M1;
      data_owner_q <= NONE;
    end else begin
      addr_owner_q <= addr_owner_d;
      data_owner_q <= data_owner_d;
    end
  end

endmodule

// File: tb/tb_rv_dual_fetch_ahb.sv
// tb/tb_rv_dual_fetch_ahb.sv - bench for rv_dual_fetch_ahb: directed literal sequences plus a
// randomized stream checked every cycle against a transaction-level bus model.
module tb_rv_dual_fetch_ahb;

  localparam logic [31:0] PAT  = 32'hA5A5_A5A5;
  localparam logic [31:0] RPC1 = 32'h0000_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req1 = 1'b0;
  logic        req2 = 1'b0;
  logic        rdy = 1'b1;
  logic [31:0] rdbus = 32'h0;
  logic [31:0] abus, wdbus, instr1, pc1, instr2, pc2;
  logic [1:0]  transbus;
  logic        instr1_vld, instr2_vld;

  int n_chk = 0;
  int n_err = 0;

  rv_dual_fetch_ahb #(.RESET_PC1(RPC1), .RESET_PC2(RPC2)) dut (
    .clk        (clk),
    .rst_n      (rst),
    .req1       (req1),
    .req2       (req2),
    .ABus       (abus),
    .TRANSBus   (transbus),
    .WDBus      (wdbus),
    .RDBus      (rdbus),
    .RDYBus     (rdy),
    .instr1_vld (instr1_vld),
    .instr1     (instr1),
    .pc1        (pc1),
    .instr2_vld (instr2_vld),
    .instr2     (instr2),
    .pc2        (pc2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the address slot, each master's next PC,
  // the single in-flight data phase, and the outputs expected after each edge.
  int          m_own = 1;
  logic [31:0] m_pc [1:2];
  bit          m_dv = 0;
  int          m_dm = 0;
  logic [31:0] m_da = 0;
  bit          e_vld [1:2];
  logic [31:0] e_ins [1:2];
  logic [31:0] e_pc  [1:2];

  function automatic bit req_of(input int m);
    return (m == 1) ? req1 : req2;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_own = 1; m_pc[1] = RPC1; m_pc[2] = RPC2; m_dv = 0; m_dm = 0;
      for (int i = 1; i <= 2; i++) begin e_vld[i] = 0; e_ins[i] = 0; e_pc[i] = 0; end
    end else begin
      e_vld[1] = 0; e_vld[2] = 0;
      if (rdy) begin
        if (m_dv) begin
          e_vld[m_dm] = 1; e_ins[m_dm] = rdbus; e_pc[m_dm] = m_da;
        end
        m_dv = req_of(m_own);
        if (m_dv) begin
          m_dm = m_own; m_da = m_pc[m_own]; m_pc[m_own] = m_pc[m_own] + 32'd4;
        end
        if (req1 && req2) m_own = 3 - m_own;
        else if (req1)    m_own = 1;
        else if (req2)    m_own = 2;
      end
    end
  endtask

  initial model_step();

  always begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Memory returns address ^ PAT for whichever fetch is in its data phase.
  always begin
    @(posedge clk);
    #2;
    rdbus = m_dv ? (m_da ^ PAT) : $urandom;
  end

  always begin
    @(negedge clk);
    if (!rst) begin
      chk("trans", {30'd0, transbus}, req_of(m_own) ? 32'd2 : 32'd0);
      if (req_of(m_own)) chk("abus", abus, m_pc[m_own]);
      chk("wdbus", wdbus, 32'd0);
      chk("vld1", {31'd0, instr1_vld}, {31'd0, e_vld[1]});
      chk("vld2", {31'd0, instr2_vld}, {31'd0, e_vld[2]});
      if (e_vld[1]) begin
        chk("pc1", pc1, e_pc[1]);
        chk("instr1", instr1, e_ins[1]);
        chk("instr1_pat", instr1, pc1 ^ PAT);
      end
      if (e_vld[2]) begin
        chk("pc2", pc2, e_pc[2]);
        chk("instr2", instr2, e_ins[2]);
        chk("instr2_pat", instr2, pc2 ^ PAT);
      end
    end
  end

  task automatic apply_reset(input logic r1, input logic r2);
    @(posedge clk); #2;
    rst = 1; req1 = 0; req2 = 0; rdy = 1;
    @(posedge clk); #2;
    rst = 0; req1 = r1; req2 = r2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_trans"}, {30'd0, transbus}, 32'd0);
    chk({tag, "_vld1"}, {31'd0, instr1_vld}, 32'd0);
    chk({tag, "_vld2"}, {31'd0, instr2_vld}, 32'd0);
    chk({tag, "_instr1"}, instr1, 32'd0);
    chk({tag, "_pc1"}, pc1, 32'd0);
    chk({tag, "_instr2"}, instr2, 32'd0);
    chk({tag, "_pc2"}, pc2, 32'd0);
    chk({tag, "_abus"}, abus, RPC1);
  endtask

  initial begin
    #1;
    chk_reset_outputs("rst0");
    chk("rst0_wdbus", wdbus, 32'd0);

    // Only master 2 requesting: one IDLE cycle to switch owner, then back-to-back fetches.
    apply_reset(1'b0, 1'b1);
    @(negedge clk); chk("A_idle", {30'd0, transbus}, 32'd0);
    @(negedge clk); chk("A_a0", abus, 32'hFFFF_FFFF);
    @(negedge clk); chk("A_a1", abus, 32'h0000_0003);
    @(negedge clk); chk("A_a2", abus, 32'h0000_0007);
    chk("A_vld2", {31'd0, instr2_vld}, 32'd1);
    chk("A_pc2", pc2, 32'hFFFF_FFFF);
    chk("A_instr2", instr2, 32'h5A5A_5A5A);

    // Both requesting: alternating ownership, then a 3-cycle stall, then req1 dropped.
    apply_reset(1'b1, 1'b1);
    @(negedge clk); chk("B_a0", abus, 32'h0000_0000);
    @(negedge clk); chk("B_a1", abus, 32'hFFFF_FFFF);
    @(negedge clk); chk("B_a2", abus, 32'h0000_0004);
    chk("B_pc1", pc1, 32'h0000_0000);
    chk("B_instr1", instr1, PAT);
    @(negedge clk); chk("B_a3", abus, 32'h0000_0003);
    chk("B_pc2", pc2, 32'hFFFF_FFFF);
    #1 rdy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("S_abus", abus, 32'h0000_0003);
      chk("S_trans", {30'd0, transbus}, 32'd2);
      chk("S_vld", {30'd0, instr1_vld, instr2_vld}, 32'd0);
    end
    #1 rdy = 1;
    @(negedge clk); chk("S_resume", abus, 32'h0000_0008);
    chk("S_vld1", {31'd0, instr1_vld}, 32'd1);
    chk("S_pc1", pc1, 32'h0000_0004);
    @(negedge clk); chk("S_a", abus, 32'h0000_0007);
    chk("S_pc2", pc2, 32'h0000_0003);
    #1 req1 = 0;
    @(negedge clk); chk("D_abus", abus, 32'h0000_000B);
    chk("D_vld1", {31'd0, instr1_vld}, 32'd1);
    chk("D_pc1", pc1, 32'h0000_0008);
    @(negedge clk); chk("D_abus2", abus, 32'h0000_000F);
    chk("D_no_vld1", {31'd0, instr1_vld}, 32'd0);
    chk("D_pc2", pc2, 32'h0000_0007);

    // Randomized stream with phases biasing toward different request mixes.
    for (int c = 0; c < 3000; c++) begin
      int mode;
      mode = (c / 60) % 4;
      @(posedge clk); #2;
      case (mode)
        0: begin req1 = $urandom_range(0, 9) < 8; req2 = $urandom_range(0, 9) < 8; end
        1: begin req1 = $urandom_range(0, 9) < 9; req2 = $urandom_range(0, 9) < 2; end
        2: begin req1 = $urandom_range(0, 9) < 2; req2 = $urandom_range(0, 9) < 9; end
        default: begin req1 = $urandom_range(0, 1); req2 = $urandom_range(0, 1); end
      endcase
      rdy = $urandom_range(0, 3) != 0;
      if (c == 1500) begin
        #1; rst = 1; req1 = 0; req2 = 0;
        @(posedge clk); #2; rst = 0;
      end
    end

    // Reset in the middle of traffic drops the in-flight fetch and restarts at the reset PCs.
    @(posedge clk); #2; req1 = 1; req2 = 1; rdy = 1;
    @(posedge clk); @(posedge clk); #3;
    rst = 1; req1 = 0; req2 = 0;
    #1;
    chk_reset_outputs("R");
    @(posedge clk); #2;
    rst = 0; req1 = 1; req2 = 1;
    @(negedge clk); chk("R_a0", abus, RPC1);
    chk("R_no_vld", {30'd0, instr1_vld, instr2_vld}, 32'd0);
    @(negedge clk); chk("R_a1", abus, RPC2);
    chk("R_still_no_vld", {30'd0, instr1_vld, instr2_vld}, 32'd0);
    @(negedge clk); chk("R_a2", abus, 32'h0000_0004);
    chk("R_vld1", {31'd0, instr1_vld}, 32'd1);
    chk("R_pc1", pc1, RPC1);

    @(posedge clk); #2; req1 = 0; req2 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
